// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package countdown_pkg;

    localparam int CNT_W_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        RUNNING = 2'b10,
        PAUSED  = 2'b11
    } state_t;

endpackage

// File: rtl/down_count_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Priority per edge: reset > load > run > hold; all outputs registered.
module down_count_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH       = CNT_W_DEFAULT,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_d;
    logic             done_q;
    logic             busy_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ARMED : IDLE;
        end else if (state_q != IDLE) begin
            if (run) begin
                if (count_q == WIDTH'(1)) begin
                    tc_d = 1'b1;
                    if (AUTO_RELOAD) begin
                        count_d = reload_q;
                        state_d = RUNNING;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else if (count_q == '0) begin
                    // Defensive: an active state with a zero count must never wrap.
                    state_d = IDLE;
                end else begin
                    count_d = count_q - WIDTH'(1);
                    state_d = RUNNING;
                end
            end else if (state_q == RUNNING) begin
                state_d = PAUSED;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    // busy mirrors the next state so it lines up with count_out.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= tc_d;
            busy_q <= (state_d != IDLE);
        end
    end

    assign count_out = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench: one stop-at-zero and one auto-reload instance on shared stimulus.
module tb_down_count_timer;

    localparam int W = 7;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         run = 1'b0;

    logic [W-1:0] count0, count1;
    logic         busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers for count, last-loaded value and done pulse.
    int m_cnt[2];
    int m_rel[2];
    int m_done[2];

    always #5 CLK = ~CLK;

    down_count_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_stop (
        .CLK(CLK), .reset(reset), .load(load), .load_val(load_val), .run(run),
        .count_out(count0), .busy(busy0), .done(done0)
    );

    down_count_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_reload (
        .CLK(CLK), .reset(reset), .load(load), .load_val(load_val), .run(run),
        .count_out(count1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input int v, input bit ru);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_cnt[k] = 0; m_rel[k] = 0; m_done[k] = 0;
            end else if (l) begin
                m_cnt[k] = v; m_rel[k] = v; m_done[k] = 0;
            end else if (ru && m_cnt[k] != 0) begin
                if (m_cnt[k] == 1) begin
                    m_done[k] = 1;
                    m_cnt[k]  = (k == 1) ? m_rel[k] : 0;
                end else begin
                    m_done[k] = 0;
                    m_cnt[k]  = m_cnt[k] - 1;
                end
            end else begin
                m_done[k] = 0;
            end
        end
    endtask

    // Apply one edge of stimulus and compare both instances against the model.
    task automatic step(input bit r, input bit l, input int v, input bit ru);
        reset = r; load = l; load_val = W'(v); run = ru;
        @(posedge CLK);
        model_edge(r, l, v, ru);
        #1;
        chk("cnt_stop",   32'(count0), 32'(m_cnt[0]));
        chk("busy_stop",  32'(busy0),  32'(m_cnt[0] != 0));
        chk("done_stop",  32'(done0),  32'(m_done[0]));
        chk("cnt_rel",    32'(count1), 32'(m_cnt[1]));
        chk("busy_rel",   32'(busy1),  32'(m_cnt[1] != 0));
        chk("done_rel",   32'(done1),  32'(m_done[1]));
    endtask

    initial begin
        int exp_ar[9];
        int dsum;
        exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_done[k] = 0;
        end

        // 1: reset dominates load and run
        step(0, 1, 9, 1);
        step(0, 1, 9, 1);
        chk("t1_cnt", 32'(count0), 32'd0);
        chk("t1_busy", 32'(busy0), 32'd0);
        chk("t1_done", 32'(done0), 32'd0);

        // 2: load 5 and count out
        step(1, 1, 5, 0);
        chk("t2_load", 32'(count0), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 1);
            chk("t2_cnt", 32'(count0), 32'(5 - i));
            chk("t2_done", 32'(done0), 32'(i == 5));
            chk("t2_busy", 32'(busy0), 32'(i != 5));
        end
        step(1, 0, 0, 1);
        chk("t2_done_off", 32'(done0), 32'd0);

        // 3: pause mid-count
        step(1, 1, 10, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            chk("t3_hold", 32'(count0), 32'd7);
            chk("t3_busy", 32'(busy0), 32'd1);
        end
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0, 1);
            chk("t3_done", 32'(done0), 32'(i == 7));
        end
        chk("t3_end", 32'(count0), 32'd0);

        // 4: auto-reload periodic tick
        step(1, 1, 3, 0);
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 0, 1);
            chk("t4_cnt", 32'(count1), 32'(exp_ar[i-1]));
            chk("t4_done", 32'(done1), 32'(i % 3 == 0));
            chk("t4_busy", 32'(busy1), 32'd1);
        end

        // 5: load zero never wraps
        step(1, 1, 0, 0);
        chk("t5_busy", 32'(busy0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1);
            chk("t5_cnt", 32'(count0), 32'd0);
            chk("t5_done", 32'(done0), 32'd0);
        end

        // 6: reset mid-count, load beats run, full-scale load
        step(1, 1, 20, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1);
        chk("t6_at4", 32'(count0), 32'd4);
        step(0, 0, 0, 1);
        chk("t6_rst_cnt", 32'(count0), 32'd0);
        chk("t6_rst_done", 32'(done0), 32'd0);
        chk("t6_rst_busy", 32'(busy0), 32'd0);
        step(1, 1, 6, 1);
        chk("t6_ld_pri", 32'(count0), 32'd6);
        step(1, 1, 127, 0);
        dsum = 0;
        for (int i = 1; i <= 127; i++) begin
            step(1, 0, 0, 1);
            if (done0) dsum++;
            if (i == 127) chk("t6_127_done", 32'(done0), 32'd1);
        end
        chk("t6_127_pulses", 32'(dsum), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit r, l, ru;
            int v;
            r  = ($urandom_range(0, 39) != 0);
            l  = ($urandom_range(0, 9) == 0);
            ru = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
            step(r, l, v, ru);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
